dmem_resp: RTL and testbench

Data-memory responder serving the load/store port of the pipelined RV32 core: accepts one word request at a time over a valid/ready handshake, performs byte-enabled writes or word reads on an internal RAM, and returns a response after a fixed, parameterised latency. It is the memory-side end of the core's data interface and is used to model a slow memory, with optional address-error reporting.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_ram.sv | 42 ++++
 rtl/dmem_resp.sv | 108 ++++++++++
 tb/tb_dmem_resp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg: shared types and constants for the dmem_resp data-memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int BE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  typedef struct packed {
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// dmem_ram: single-port word RAM, per-byte write enables, synchronous read
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [BE_W-1:0] i_be,
  input  logic [AW-1:0]   i_addr,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Contents are deliberately unreset so they survive a responder reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_resp.sv
// ============================================================================
// dmem_resp: load/store responder with fixed LATENCY; optional address-error
// reporting enabled by defining DMEM_RESP_ERR_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] C_RELOAD = CW'(LATENCY - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_load;
  dmem_req_t     w_req;
  logic          w_accept;
  logic          w_err;
  logic          w_ram_en;
  logic [31:0]   w_ram_rdata;

  assign w_req    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign w_accept = req_valid && (r_state == IDLE);

`ifdef DMEM_RESP_ERR_EN
  // Power-of-two depth: addr >= 4*DEPTH_WORDS iff any bit above the index is set.
  assign w_err = (w_req.addr[1:0] != 2'b00) || (w_req.addr[31:AW+2] != '0);
`else
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_unused = ^{w_req.addr[31:AW+2], w_req.addr[1:0]};
`endif

  assign w_ram_en = w_accept && !w_err;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_req.we),
    .i_be    (w_req.be),
    .i_addr  (w_req.addr[AW+1:2]),
    .i_wdata (w_req.wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_err  <= w_err;
            r_load <= !w_req.we && !w_err;
            if (LATENCY > 1) begin
              r_cnt   <= C_RELOAD;
              r_state <= WAIT;
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The RAM read register only changes on an accept, so gating it with the
  // registered load flag yields a stable, zero-for-store/error response.
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_load ? w_ram_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
// tb_dmem_resp: self-checking bench for dmem_resp against a word-array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem  [DEPTH];
  logic [3:0]  m_known[DEPTH];

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Apply a request to the model; returns the response it should produce.
  task automatic m_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output bit er,
                         output bit known);
    int idx;
    er = m_err(a); idx = m_idx(a); rd = 32'd0; known = 1'b1;
    if (!er && !we) begin
      rd = m_mem[idx];
      known = (m_known[idx] == 4'hF);
    end
    if (!er && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          m_mem[idx][8*b +: 8] = wd[8*b +: 8];
          m_known[idx][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_req(input string nm, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] exp_rd; bit exp_er, known; int n;
    m_apply(we, a, wd, be, exp_rd, exp_er, known);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL %s accept timeout req_ready=%b required=1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1; req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!rsp_valid || n != LAT - 1) begin
      failures++;
      $display("FAIL %s latency edges=%0d valid=%b required=%0d", nm, n, rsp_valid, LAT - 1);
      return;
    end
    checks++;
    if (rsp_err !== exp_er) begin
      failures++;
      $display("FAIL %s err actual=%b required=%b", nm, rsp_err, exp_er);
    end
    if (known) begin
      checks++;
      if (rsp_rdata !== exp_rd) begin
        failures++;
        $display("FAIL %s rdata actual=%h required=%h", nm, rsp_rdata, exp_rd);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake valid=%b ready=%b required 0/1", nm, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = '0; end
    #12;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b rdata=%h err=%b required 0/0/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready actual=%b required=1", req_ready);
    end
  endtask

  task automatic test_store_load;
    do_req("store_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    do_req("load_full",  1'b0, 32'h10, 32'h0, 4'b0000);
  endtask

  task automatic test_byte_enable;
    do_req("store_be0101", 1'b1, 32'h10, 32'h11223344, 4'b0101);
    do_req("load_be0101",  1'b0, 32'h10, 32'h0, 4'b0000);
  endtask

  task automatic test_backpressure;
    logic [31:0] e1, e2; bit er, kn; int n; bit bad;
    do_req("bp_store", 1'b1, 32'h30, 32'h0BADF00D, 4'b1111);
    m_apply(1'b0, 32'h30, 32'h0, 4'h0, e1, er, kn);
    m_apply(1'b0, 32'h10, 32'h0, 4'h0, e2, er, kn);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_be = 4'h0;
    @(posedge clk); #1;
    req_addr = 32'h10;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e1 || req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold valid=%b rdata=%h ready=%b required 1/%h/0",
               rsp_valid, rsp_rdata, req_ready, e1);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_same_cycle_accept valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1; req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept ready=%b required=0", req_ready);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e2) begin
      failures++;
      $display("FAIL bp_second_rdata valid=%b rdata=%h required 1/%h", rsp_valid, rsp_rdata, e2);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_errors;
    do_req("err_init_w0",  1'b1, 32'h0, 32'h01020304, 4'b1111);
    do_req("err_load_13",  1'b0, 32'h13, 32'h0, 4'b0000);
    do_req("err_store_oob", 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'b1111);
    do_req("err_check_w0", 1'b0, 32'h0, 32'h0, 4'b0000);
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; bit er, kn; bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A55A5A; req_be = 4'hF;
    m_apply(1'b1, 32'h20, 32'hA5A55A5A, 4'hF, rd, er, kn);
    @(posedge clk); #2; req_valid = 1'b0; reset = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL rst_wait_immediate valid=%b err=%b rdata=%h required 0/0/0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_wait_no_response rsp_valid seen=1 required=0");
    end
    do_req("rst_wait_load", 1'b0, 32'h20, 32'h0, 4'b0000);
  endtask

  task automatic test_random;
    logic we; logic [31:0] a; int w;
    for (int i = 0; i < 16; i++) do_req("rnd_init", 1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 15);
      a  = 32'(w * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH);
      do_req("rnd", we, a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_errors();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
